// File: rtl/ip_rx_if.sv
// ip_rx_if: MAC-side byte stream into the IPv4 parser and payload stream out to the upper layers.
//   i_mac_data/type/last/valid : frame bytes from the MAC RX layer (IP header first)
//   o_recv_data/type/len/last/valid : payload stream with protocol and payload length
//   o_src_ip/o_src_ip_valid : source address of the accepted packet, pulse on header accept
//   master modport drives the MAC side, slave modport is the parser view.
interface ip_rx_if;
   logic [7:0]  i_mac_data;
   logic [15:0] i_mac_type;
   logic        i_mac_last;
   logic        i_mac_valid;
   logic [7:0]  o_recv_data;
   logic [7:0]  o_recv_type;
   logic [15:0] o_recv_len;
   logic        o_recv_last;
   logic        o_recv_valid;
   logic [31:0] o_src_ip;
   logic        o_src_ip_valid;
   modport master (
      output i_mac_data, i_mac_type, i_mac_last, i_mac_valid,
      input  o_recv_data, o_recv_type, o_recv_len, o_recv_last, o_recv_valid, o_src_ip, o_src_ip_valid
   );
   modport slave (
      input  i_mac_data, i_mac_type, i_mac_last, i_mac_valid,
      output o_recv_data, o_recv_type, o_recv_len, o_recv_last, o_recv_valid, o_src_ip, o_src_ip_valid
   );
endinterface

// File: rtl/ip_rx.sv
// ip_rx: IPv4 receive parser, validates and strips the 20-byte header and streams the payload upward.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_local_ip(_valid)  : loads a new local IP address (reset value P_LOCAL_IP)
//   bus (ip_rx_if.slave): MAC byte stream in, payload stream, protocol, length and source IP out
//   Define IP_RX_CHKSUM_EN to reject frames whose header checksum is wrong.
module ip_rx #(
   parameter logic [31:0] P_LOCAL_IP = {8'd192, 8'd168, 8'd1, 8'd1},
   parameter logic [15:0] P_TYPE_IP  = 16'h0800
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_local_ip,
   input  logic        i_local_ip_valid,
   ip_rx_if.slave      bus
);
   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DROP} state_t;
   state_t      state, state_nxt;
   logic [15:0] cnt, total_len;
   logic [7:0]  proto;
   logic [31:0] local_ip, local_snap, src;
   logic [23:0] dst;
   logic        frag_bad;
   logic        hdr_byte, chk_ok, dst_ok, accept, emit, emit_last;
   logic        p_valid, p_last;
   logic [7:0]  p_data;

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) state <= IDLE;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      if (bus.i_mac_valid)
         if (bus.i_mac_last) state_nxt = IDLE;
         else
            case (state)
               IDLE:    state_nxt = (bus.i_mac_type == P_TYPE_IP && bus.i_mac_data == 8'h45) ? HEADER : DROP;
               HEADER:  state_nxt = cnt != 16'd19 ? HEADER : (accept && total_len != 16'd20) ? PAYLOAD : DROP;
               PAYLOAD: state_nxt = emit_last ? DROP : PAYLOAD;
               default: state_nxt = DROP;
            endcase
   end

   // The decision on byte 19 sees the last destination byte directly off the bus.
   always_comb begin
      hdr_byte  = bus.i_mac_valid && (state == IDLE || state == HEADER);
      dst_ok    = {dst, bus.i_mac_data} == local_snap || {dst, bus.i_mac_data} == 32'hFFFF_FFFF;
      accept    = state == HEADER && bus.i_mac_valid && cnt == 16'd19 && !frag_bad &&
                  total_len >= 16'd20 && dst_ok && chk_ok;
      emit      = state == PAYLOAD && bus.i_mac_valid;
      emit_last = emit && (cnt == total_len - 16'd1 || bus.i_mac_last);
   end

`ifdef IP_RX_CHKSUM_EN
   logic [7:0]  hi;
   logic [15:0] acc, fold;
   logic [16:0] sum;
   // Each odd byte completes a 16-bit word; byte 1 restarts the running sum.
   always_comb begin
      sum    = (cnt == 16'd1 ? 17'd0 : {1'b0, acc}) + {1'b0, hi, bus.i_mac_data};
      fold   = sum[15:0] + {15'd0, sum[16]};
      chk_ok = fold == 16'hFFFF;
   end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         hi  <= '0;
         acc <= '0;
      end else if (hdr_byte) begin
         hi  <= bus.i_mac_data;
         acc <= cnt[0] ? fold : acc;
      end
`else
   assign chk_ok = 1'b1;
`endif

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         local_ip   <= P_LOCAL_IP;
         local_snap <= '0;
         cnt        <= '0;
         total_len  <= '0;
         frag_bad   <= 1'b0;
         proto      <= '0;
         src        <= '0;
         dst        <= '0;
      end else begin
         if (i_local_ip_valid) local_ip <= i_local_ip;
         if (bus.i_mac_valid) cnt <= bus.i_mac_last ? 16'd0 : cnt + {15'd0, cnt != 16'hFFFF};
         if (hdr_byte)
            case (cnt)
               16'd2:  total_len[15:8] <= bus.i_mac_data;
               16'd3:  total_len[7:0] <= bus.i_mac_data;
               16'd6:  frag_bad <= bus.i_mac_data[5] | (|bus.i_mac_data[4:0]);
               16'd7:  frag_bad <= frag_bad | (|bus.i_mac_data);
               16'd9:  proto <= bus.i_mac_data;
               16'd12, 16'd13, 16'd14, 16'd15: src <= {src[23:0], bus.i_mac_data};
               // The local address in force when byte 16 arrives is the one this frame is checked against.
               16'd16: begin
                  dst        <= {dst[15:0], bus.i_mac_data};
                  local_snap <= local_ip;
               end
               16'd17, 16'd18: dst <= {dst[15:0], bus.i_mac_data};
               default: ;
            endcase
      end

   // Two register stages give the fixed two-cycle input-to-output latency.
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         p_valid            <= 1'b0;
         p_last             <= 1'b0;
         p_data             <= '0;
         bus.o_recv_valid   <= 1'b0;
         bus.o_recv_last    <= 1'b0;
         bus.o_recv_data    <= '0;
         bus.o_recv_type    <= '0;
         bus.o_recv_len     <= '0;
         bus.o_src_ip       <= '0;
         bus.o_src_ip_valid <= 1'b0;
      end else begin
         p_valid            <= emit;
         p_last             <= emit_last;
         p_data             <= bus.i_mac_data;
         bus.o_recv_valid   <= p_valid;
         bus.o_recv_last    <= p_last;
         bus.o_recv_data    <= p_data;
         bus.o_src_ip_valid <= accept;
         if (accept) begin
            bus.o_src_ip    <= src;
            bus.o_recv_type <= proto;
            bus.o_recv_len  <= total_len - 16'd20;
         end
      end
endmodule

// File: tb/tb_ip_rx.sv
// tb_ip_rx: directed bench for ip_rx covering accept, padding, address, checksum, type, truncation and reset cases.
module tb_ip_rx;
   localparam logic [15:0] IP  = 16'h0800;
   localparam logic [31:0] LOC = 32'hC0A8_0101;
`ifdef IP_RX_CHKSUM_EN
   localparam int BAD_SUM_BYTES = 0;
`else
   localparam int BAD_SUM_BYTES = 16;
`endif
   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] local_ip = '0;
   logic        local_ip_valid = 1'b0;
   int          cyc = 0, in20 = 0, sv_tot = 0, errors = 0, checks = 0;
   logic [7:0]  q_d[$];
   logic        q_l[$];
   int          q_c[$];
   logic [7:0]  frm [0:99];

   ip_rx_if bus();
   ip_rx dut (.i_clk(clk), .i_rst(rst), .i_local_ip(local_ip), .i_local_ip_valid(local_ip_valid), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (bus.o_recv_valid) begin
         q_d.push_back(bus.o_recv_data);
         q_l.push_back(bus.o_recv_last);
         q_c.push_back(cyc);
      end
      if (bus.o_src_ip_valid) sv_tot++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Header: 45 00 len 0000 fl 00 40 pr csum 0a000005 dst; payload byte k = k.
   task automatic build(input int tl, input logic [7:0] pr, input logic [31:0] dst, input logic [7:0] fl);
      logic [16:0] s;
      logic [15:0] acc;
      for (int i = 0; i < 100; i++) frm[i] = 8'(i - 20);
      {frm[0], frm[1], frm[2], frm[3]} = {8'h45, 8'h00, 16'(tl)};
      {frm[4], frm[5], frm[6], frm[7]} = {16'h0000, fl, 8'h00};
      {frm[8], frm[9], frm[10], frm[11]} = {8'h40, pr, 16'h0000};
      {frm[12], frm[13], frm[14], frm[15]} = 32'h0A00_0005;
      {frm[16], frm[17], frm[18], frm[19]} = dst;
      acc = '0;
      for (int w = 0; w < 10; w++) begin
         s   = {1'b0, acc} + {1'b0, frm[2*w], frm[2*w+1]};
         acc = s[15:0] + {15'd0, s[16]};
      end
      {frm[10], frm[11]} = ~acc;
   endtask

   task automatic drive(input int lo, input int hi, input logic [15:0] typ, input logic fin);
      for (int i = lo; i < hi; i++) begin
         @(posedge clk);
         #1;
         bus.i_mac_valid = 1'b1;
         bus.i_mac_data  = frm[i];
         bus.i_mac_type  = typ;
         bus.i_mac_last  = fin && i == hi - 1;
         if (i == 20) in20 = cyc;
      end
   endtask

   task automatic idle(input int k);
      @(posedge clk);
      #1;
      bus.i_mac_valid = 1'b0;
      bus.i_mac_last  = 1'b0;
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic chk_burst(input string tag, input int b, input int n);
      int lasts;
      lasts = 0;
      chk({tag, " count"}, 32'(q_d.size() - b), 32'(n));
      for (int i = b; i < q_d.size(); i++) begin
         chk({tag, " data"}, 32'(q_d[i]), 32'(i - b));
         if (i > b) chk({tag, " gap"}, 32'(q_c[i]), 32'(q_c[i-1] + 1));
         lasts += int'(q_l[i]);
      end
      if (q_d.size() > b) begin
         chk({tag, " latency"}, 32'(q_c[b]), 32'(in20 + 2));
         chk({tag, " last pos"}, 32'(q_l[q_l.size()-1]), 32'd1);
         chk({tag, " last count"}, 32'(lasts), 32'd1);
      end
   endtask

   task automatic set_local(input logic [31:0] ip);
      @(posedge clk);
      #1;
      local_ip = ip;
      local_ip_valid = 1'b1;
      @(posedge clk);
      #1;
      local_ip_valid = 1'b0;
   endtask

   initial begin
      int b, s;
      bus.i_mac_valid = 1'b0;
      bus.i_mac_data  = '0;
      bus.i_mac_type  = '0;
      bus.i_mac_last  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst valid", 32'(bus.o_recv_valid), 32'd0);
      chk("rst last", 32'(bus.o_recv_last), 32'd0);
      chk("rst len", 32'(bus.o_recv_len), 32'd0);
      chk("rst src", bus.o_src_ip, 32'd0);
      chk("rst src valid", 32'(bus.o_src_ip_valid), 32'd0);

      build(36, 8'd17, LOC, 8'h40);
      b = q_d.size(); s = sv_tot;
      drive(0, 36, IP, 1'b1); idle(6);
      chk("udp pulse", 32'(sv_tot - s), 32'd1);
      chk_burst("udp", b, 16);
      chk("udp type", 32'(bus.o_recv_type), 32'd17);
      chk("udp len", 32'(bus.o_recv_len), 32'd16);
      chk("udp src", bus.o_src_ip, 32'h0A00_0005);

      build(28, 8'd1, LOC, 8'h00);
      b = q_d.size(); s = sv_tot;
      drive(0, 46, IP, 1'b1); idle(6);
      chk("icmp pulse", 32'(sv_tot - s), 32'd1);
      chk_burst("icmp", b, 8);
      chk("icmp type", 32'(bus.o_recv_type), 32'd1);
      chk("icmp len", 32'(bus.o_recv_len), 32'd8);

      build(36, 8'd17, 32'hC0A8_0107, 8'h40);
      b = q_d.size(); s = sv_tot;
      drive(0, 36, IP, 1'b1); idle(6);
      chk("other dst count", 32'(q_d.size() - b), 32'd0);
      chk("other dst pulse", 32'(sv_tot - s), 32'd0);
      set_local(32'hC0A8_0107);
      b = q_d.size(); s = sv_tot;
      drive(0, 36, IP, 1'b1); idle(6);
      chk("new local pulse", 32'(sv_tot - s), 32'd1);
      chk_burst("new local", b, 16);
      set_local(LOC);

      build(36, 8'd17, LOC, 8'h40);
      frm[15] = frm[15] ^ 8'h01;
      b = q_d.size();
      drive(0, 36, IP, 1'b1); idle(6);
      chk("bad sum count", 32'(q_d.size() - b), 32'(BAD_SUM_BYTES));

      build(36, 8'd17, LOC, 8'h40);
      b = q_d.size(); s = sv_tot;
      drive(0, 36, 16'h0806, 1'b1);
      drive(0, 36, IP, 1'b1); idle(6);
      chk("b2b pulse", 32'(sv_tot - s), 32'd1);
      chk_burst("b2b", b, 16);

      build(28, 8'd1, 32'hFFFF_FFFF, 8'h00);
      b = q_d.size();
      drive(0, 28, IP, 1'b1); idle(6);
      chk_burst("bcast", b, 8);

      build(36, 8'd17, LOC, 8'h20);
      b = q_d.size(); s = sv_tot;
      drive(0, 36, IP, 1'b1); idle(6);
      chk("frag count", 32'(q_d.size() - b), 32'd0);
      chk("frag pulse", 32'(sv_tot - s), 32'd0);

      build(20, 8'd17, LOC, 8'h40);
      b = q_d.size(); s = sv_tot;
      drive(0, 46, IP, 1'b1); idle(6);
      chk("empty pulse", 32'(sv_tot - s), 32'd1);
      chk("empty count", 32'(q_d.size() - b), 32'd0);
      chk("empty len", 32'(bus.o_recv_len), 32'd0);

      build(36, 8'd17, LOC, 8'h40);
      b = q_d.size();
      drive(0, 30, IP, 1'b1); idle(6);
      chk_burst("trunc", b, 10);

      build(60, 8'd17, LOC, 8'h40);
      b = q_d.size(); s = sv_tot;
      drive(0, 28, IP, 1'b0);
      #2;
      chk("mid burst valid", 32'(bus.o_recv_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid rst valid", 32'(bus.o_recv_valid), 32'd0);
      chk("mid rst data", 32'(bus.o_recv_data), 32'd0);
      chk("mid rst last", 32'(bus.o_recv_last), 32'd0);
      chk("mid rst len", 32'(bus.o_recv_len), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      begin
         int lasts;
         lasts = 0;
         for (int i = b; i < q_l.size(); i++) lasts += int'(q_l[i]);
         chk("pre rst lasts", 32'(lasts), 32'd0);
      end
      b = q_d.size();
      drive(28, 60, IP, 1'b1); idle(6);
      chk("post rst count", 32'(q_d.size() - b), 32'd0);
      chk("post rst pulse", 32'(sv_tot - s), 32'd1);

      build(36, 8'd17, LOC, 8'h40);
      b = q_d.size();
      drive(0, 36, IP, 1'b1); idle(6);
      chk_burst("after rst", b, 16);
      chk("after rst len", 32'(bus.o_recv_len), 32'd16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
